// File: rtl/arith_extend_arbiter.sv
// Round-robin arbiter that shares one pipelined extender among REQ_N requesters,
// tagging issued requests and returning results in grant order through a credited FIFO.
module arith_extend_arbiter #(
    parameter int REQ_N     = 3,
    parameter int IN_W      = 4,
    parameter int OUT_W     = 8,
    parameter int LATENCY   = 1,
    parameter int RSP_DEPTH = 4,
    parameter int ID_W      = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [REQ_N-1:0]             i_req_valid,
    input  logic [REQ_N-1:0][IN_W-1:0]   i_req_data,
    input  logic [REQ_N-1:0]             i_req_sign,
    output logic [REQ_N-1:0]             o_req_ready,
    output logic [IN_W-1:0]              o_ext_in,
    output logic                         o_ext_sign,
    input  logic [OUT_W-1:0]             i_ext_out,
    output logic                         o_rsp_valid,
    output logic [ID_W-1:0]              o_rsp_id,
    output logic [OUT_W-1:0]             o_rsp_data,
    input  logic                         i_rsp_ready
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [ID_W-1:0]  r_rr_ptr;
    logic [LATENCY-1:0] r_tag_vld;
    logic [ID_W-1:0]  r_tag_id [LATENCY];
    logic [ID_W-1:0]  r_mem_id [RSP_DEPTH];
    logic [OUT_W-1:0] r_mem_data [RSP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_credits;

    logic             w_grant_any;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] f_fifo_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Scan from the pointer downward in offset so the smallest offset is written last and wins.
    always_comb begin
        logic [ID_W-1:0] w_idx;
        w_idx       = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % REQ_N);
            if (i_req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_idx;
            end
        end
        if (!i_rst_n || r_credits == '0) begin
            w_grant_any = 1'b0;
        end
    end

    always_comb begin
        o_req_ready = '0;
        o_ext_in    = '0;
        o_ext_sign  = 1'b0;
        if (w_grant_any) begin
            o_req_ready[w_grant_id] = 1'b1;
            o_ext_in                = i_req_data[w_grant_id];
            o_ext_sign              = i_req_sign[w_grant_id];
        end
    end

    assign w_push      = r_tag_vld[LATENCY-1];
    assign o_rsp_valid = i_rst_n && (r_count != '0);
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign o_rsp_id    = r_mem_id[r_rd_ptr];
    assign o_rsp_data  = r_mem_data[r_rd_ptr];

    // Tag ids and FIFO storage carry data only; their validity lives in the control registers.
    always_ff @(posedge i_clk) begin
        r_tag_id[0] <= w_grant_id;
        for (int i = 1; i < LATENCY; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
        end
        if (w_push) begin
            r_mem_id[r_wr_ptr]   <= r_tag_id[LATENCY-1];
            r_mem_data[r_wr_ptr] <= i_ext_out;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_ptr  <= '0;
            r_tag_vld <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_credits <= CNT_W'(RSP_DEPTH);
        end else begin
            assert (!(w_push && r_count == CNT_W'(RSP_DEPTH)));
            if (w_grant_any) begin
                r_rr_ptr <= (int'(w_grant_id) == REQ_N - 1) ? '0 : w_grant_id + 1'b1;
            end
            r_tag_vld[0] <= w_grant_any;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
            if (w_push) begin
                r_wr_ptr <= f_fifo_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_fifo_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_grant_any, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule
